player_core: RTL

//  Executes the player instruction stream emitted by the game state machine during DODGE.

---
 rtl/player_core.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/player_core.sv
`default_nettype none
// ============================================================================
// Module   : player_core
// Purpose  : Executes DODGE-phase player instructions: HP, heart position and
//            death flag. Define PLAYER_INVULN_EN for post-hit invulnerability.
// Revision : 1.0 - initial release
// ============================================================================
module player_core #(
  parameter int HP_MAX        = 100,
  parameter int BOX_X0        = 240,
  parameter int BOX_X1        = 400,
  parameter int BOX_Y0        = 280,
  parameter int BOX_Y1        = 420,
  parameter int STEP          = 2,
  parameter int MOVE_DIV      = 250000,
  parameter int INVULN_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_playerInstruction,
  input  logic        i_isMove,
  input  logic        i_startDmg,
  output logic [7:0]  o_hp,
  output logic [9:0]  o_posX,
  output logic [9:0]  o_posY,
  output logic        o_isDeath,
  output logic        o_hpChange,
  output logic        o_invuln
);

  localparam logic [3:0]         C_OP_HPY = 4'd1;
  localparam logic [3:0]         C_OP_DPY = 4'd2;
  localparam logic [3:0]         C_OP_MOV = 4'd5;
  localparam logic [3:0]         C_OP_SHP = 4'd6;
  localparam logic [7:0]         C_HP_MAX = 8'(HP_MAX);
  localparam logic [9:0]         C_X_MID  = 10'((BOX_X0 + BOX_X1) / 2);
  localparam logic [9:0]         C_Y_MID  = 10'((BOX_Y0 + BOX_Y1) / 2);
  localparam logic signed [10:0] C_X0     = 11'(BOX_X0);
  localparam logic signed [10:0] C_X1     = 11'(BOX_X1);
  localparam logic signed [10:0] C_Y0     = 11'(BOX_Y0);
  localparam logic signed [10:0] C_Y1     = 11'(BOX_Y1);
  localparam logic signed [10:0] C_STEP   = 11'(STEP);
  localparam int                 C_MCNT_W = $clog2(MOVE_DIV + 1);
  localparam logic [C_MCNT_W-1:0] C_MCNT_LAST = C_MCNT_W'(MOVE_DIV - 1);

  typedef enum logic [1:0] {
    S_ALIVE = 2'd0,
    S_HIT   = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_hp, w_hp_nxt;
  logic [9:0]          r_posX, r_posY, w_posX_nxt, w_posY_nxt;
  logic [15:0]         r_prev_instr;
  logic                r_dmg_q, r_hpChange;
  logic [C_MCNT_W-1:0] r_move_cnt;

  logic [3:0]          w_op;
  logic [7:0]          w_operand;
  logic                w_shp, w_dmg_edge, w_hpy, w_dpy, w_mov_held, w_mov;
  logic [8:0]          w_heal_sum;
  logic signed [10:0]  w_x_s, w_y_s;

`ifdef PLAYER_INVULN_EN
  localparam int                  C_ICNT_W    = $clog2(INVULN_CYCLES + 1);
  localparam logic [C_ICNT_W-1:0] C_ICNT_LAST = C_ICNT_W'(INVULN_CYCLES - 1);
  logic [C_ICNT_W-1:0] r_inv_cnt;
  logic                w_inv_done;
  assign w_inv_done = (r_inv_cnt == C_ICNT_LAST);
`endif

  function automatic logic [9:0] f_clamp(input logic signed [10:0] v,
                                         input logic signed [10:0] lo,
                                         input logic signed [10:0] hi);
    if (v < lo) return lo[9:0];
    if (v > hi) return hi[9:0];
    return v[9:0];
  endfunction

  assign w_op       = i_playerInstruction[15:12];
  assign w_operand  = i_playerInstruction[11:4];
  assign w_shp      = (w_op == C_OP_SHP) && (i_playerInstruction != r_prev_instr);
  assign w_dmg_edge = i_startDmg && !r_dmg_q;
  assign w_hpy      = w_dmg_edge && (w_op == C_OP_HPY) && (r_state != S_DEAD);
  // HIT only exists in the invulnerable build, so ALIVE-only is exact in both.
  assign w_dpy      = w_dmg_edge && (w_op == C_OP_DPY) && (r_state == S_ALIVE);
  assign w_mov_held = (w_op == C_OP_MOV) && i_isMove;
  assign w_mov      = w_mov_held && (r_move_cnt == '0) && (r_state != S_DEAD);
  assign w_heal_sum = {1'b0, r_hp} + {1'b0, w_operand};

  always_comb begin
    w_hp_nxt    = r_hp;
    w_posX_nxt  = r_posX;
    w_posY_nxt  = r_posY;
    w_state_nxt = r_state;
    w_x_s       = $signed({1'b0, r_posX});
    w_y_s       = $signed({1'b0, r_posY});
    if (w_shp) begin
      w_hp_nxt    = (w_operand > C_HP_MAX) ? C_HP_MAX : w_operand;
      w_posX_nxt  = C_X_MID;
      w_posY_nxt  = C_Y_MID;
      w_state_nxt = (w_operand == 8'd0) ? S_DEAD : S_ALIVE;
    end else if (w_hpy) begin
      w_hp_nxt = (w_heal_sum > {1'b0, C_HP_MAX}) ? C_HP_MAX : w_heal_sum[7:0];
    end else if (w_dpy) begin
      w_hp_nxt = (w_operand >= r_hp) ? 8'd0 : r_hp - w_operand;
      if (w_operand >= r_hp)
        w_state_nxt = S_DEAD;
`ifdef PLAYER_INVULN_EN
      else if (w_operand != 8'd0)
        w_state_nxt = S_HIT;
`endif
    end else if (w_mov) begin
      case (w_operand[1:0])
        2'd0:    w_y_s = w_y_s - C_STEP;
        2'd1:    w_x_s = w_x_s - C_STEP;
        2'd2:    w_y_s = w_y_s + C_STEP;
        default: w_x_s = w_x_s + C_STEP;
      endcase
      w_posX_nxt = f_clamp(w_x_s, C_X0, C_X1);
      w_posY_nxt = f_clamp(w_y_s, C_Y0, C_Y1);
    end
`ifdef PLAYER_INVULN_EN
    if (!w_shp && (r_state == S_HIT) && w_inv_done)
      w_state_nxt = S_ALIVE;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ALIVE;
      r_hp         <= C_HP_MAX;
      r_posX       <= C_X_MID;
      r_posY       <= C_Y_MID;
      r_prev_instr <= '0;
      r_dmg_q      <= 1'b0;
      r_hpChange   <= 1'b0;
      r_move_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_hp         <= w_hp_nxt;
      r_posX       <= w_posX_nxt;
      r_posY       <= w_posY_nxt;
      r_prev_instr <= i_playerInstruction;
      r_dmg_q      <= i_startDmg;
      r_hpChange   <= (w_hp_nxt != r_hp);
      // Counter sits at zero until the key is held, so the first step is immediate.
      if (!w_mov_held || (r_move_cnt == C_MCNT_LAST))
        r_move_cnt <= '0;
      else
        r_move_cnt <= r_move_cnt + 1'b1;
    end
  end

`ifdef PLAYER_INVULN_EN
  always_ff @(posedge clk) begin
    if (reset)
      r_inv_cnt <= '0;
    else if ((r_state == S_HIT) && (w_state_nxt == S_HIT))
      r_inv_cnt <= r_inv_cnt + 1'b1;
    else
      r_inv_cnt <= '0;
  end
  assign o_invuln = (r_state == S_HIT);
`else
  assign o_invuln = 1'b0;
`endif

  assign o_hp       = r_hp;
  assign o_posX     = r_posX;
  assign o_posY     = r_posY;
  assign o_isDeath  = (r_state == S_DEAD);
  assign o_hpChange = r_hpChange;

endmodule
`default_nettype wire
